// File: rtl/mobo_bus_arb.sv
// mobo_bus_arb: arbitrates N_CH requesters onto one single-port RAM with WAIT_CYC wait states.
// Define MOBO_BUS_RR_EN for round-robin arbitration; otherwise the lowest-index requester wins.
module mobo_bus_arb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 32,
   parameter int N_CH     = 2,
   parameter int WAIT_CYC = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_CH-1:0]          ch_req,
   input  logic [N_CH-1:0]          ch_we,
   input  logic [N_CH*ADDR_W-1:0]   ch_addr,
   input  logic [N_CH*DATA_W-1:0]   ch_wdata,
   output logic [N_CH-1:0]          ch_ack,
   output logic [DATA_W-1:0]        ch_rdata,
   output logic [ADDR_W-1:0]        ram_addr,
   output logic [DATA_W-1:0]        ram_wdata,
   input  logic [DATA_W-1:0]        ram_rdata,
   output logic                     ram_rd,
   output logic                     ram_wr,
   output logic                     busy
);

   localparam int              GW        = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [7:0]      WAIT_LAST = 8'(WAIT_CYC);
   localparam logic [N_CH-1:0] ACK_ONE   = N_CH'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t              state_r, state_s;
   logic [7:0]          cnt_r, cnt_s;
   logic [GW-1:0]       grant_r, grant_s;
   logic                we_r, we_s;
   logic [ADDR_W-1:0]   ram_addr_r, ram_addr_s;
   logic [DATA_W-1:0]   ram_wdata_r, ram_wdata_s;
   logic                ram_rd_r, ram_rd_s;
   logic                ram_wr_r, ram_wr_s;
   logic [N_CH-1:0]     ch_ack_r, ch_ack_s;
   logic [DATA_W-1:0]   ch_rdata_r, ch_rdata_s;
   logic                busy_r, busy_s;

   logic                found_s;
   logic [GW-1:0]       win_s;
   logic                win_we_s;
   logic [ADDR_W-1:0]   win_addr_s;
   logic [DATA_W-1:0]   win_wdata_s;

`ifdef MOBO_BUS_RR_EN
   logic [GW-1:0]       rr_ptr_r;

   // Round-robin winner: first sweep channels above the last grant, then wrap to the rest
   always_comb begin
      found_s     = 1'b0;
      win_s       = '0;
      win_we_s    = 1'b0;
      win_addr_s  = '0;
      win_wdata_s = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (!found_s && ch_req[i] && (GW'(i) > rr_ptr_r)) begin
            found_s     = 1'b1;
            win_s       = GW'(i);
            win_we_s    = ch_we[i];
            win_addr_s  = ch_addr[i*ADDR_W +: ADDR_W];
            win_wdata_s = ch_wdata[i*DATA_W +: DATA_W];
         end else begin
            found_s     = found_s;
         end
      end
      for (int i = 0; i < N_CH; i++) begin
         if (!found_s && ch_req[i] && (GW'(i) <= rr_ptr_r)) begin
            found_s     = 1'b1;
            win_s       = GW'(i);
            win_we_s    = ch_we[i];
            win_addr_s  = ch_addr[i*ADDR_W +: ADDR_W];
            win_wdata_s = ch_wdata[i*DATA_W +: DATA_W];
         end else begin
            found_s     = found_s;
         end
      end
   end

   // Pointer remembers the last grant so the search starts just after it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_r <= GW'(N_CH - 1);
      end else if (state_r == IDLE && found_s) begin
         rr_ptr_r <= win_s;
      end else begin
         rr_ptr_r <= rr_ptr_r;
      end
   end
`else
   // Fixed-priority winner: lowest-index requesting channel
   always_comb begin
      found_s     = 1'b0;
      win_s       = '0;
      win_we_s    = 1'b0;
      win_addr_s  = '0;
      win_wdata_s = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (!found_s && ch_req[i]) begin
            found_s     = 1'b1;
            win_s       = GW'(i);
            win_we_s    = ch_we[i];
            win_addr_s  = ch_addr[i*ADDR_W +: ADDR_W];
            win_wdata_s = ch_wdata[i*DATA_W +: DATA_W];
         end else begin
            found_s     = found_s;
         end
      end
   end
`endif

   // Next-state and next-output logic; strobes and ack are computed one cycle ahead so they leave flops
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      grant_s     = grant_r;
      we_s        = we_r;
      ram_addr_s  = ram_addr_r;
      ram_wdata_s = ram_wdata_r;
      ram_rd_s    = 1'b0;
      ram_wr_s    = 1'b0;
      ch_ack_s    = '0;
      ch_rdata_s  = ch_rdata_r;
      case (state_r)
         IDLE: begin
            if (found_s) begin
               state_s     = ACCESS;
               cnt_s       = 8'd0;
               grant_s     = win_s;
               we_s        = win_we_s;
               ram_addr_s  = win_addr_s;
               ram_wdata_s = win_wdata_s;
               ram_rd_s    = ~win_we_s;
               ram_wr_s    = win_we_s;
            end else begin
               state_s     = IDLE;
            end
         end
         ACCESS: begin
            if (cnt_r == WAIT_LAST) begin
               state_s  = DONE;
               ch_ack_s = ACK_ONE << grant_r;
               if (!we_r) begin
                  ch_rdata_s = ram_rdata;
               end else begin
                  ch_rdata_s = ch_rdata_r;
               end
            end else begin
               cnt_s    = cnt_r + 8'd1;
               ram_rd_s = ~we_r;
               ram_wr_s = we_r;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
      busy_s = (state_s != IDLE);
   end

   // State and output registers; reset aborts any access in flight without an ack
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         cnt_r       <= 8'd0;
         grant_r     <= '0;
         we_r        <= 1'b0;
         ram_addr_r  <= '0;
         ram_wdata_r <= '0;
         ram_rd_r    <= 1'b0;
         ram_wr_r    <= 1'b0;
         ch_ack_r    <= '0;
         ch_rdata_r  <= '0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         grant_r     <= grant_s;
         we_r        <= we_s;
         ram_addr_r  <= ram_addr_s;
         ram_wdata_r <= ram_wdata_s;
         ram_rd_r    <= ram_rd_s;
         ram_wr_r    <= ram_wr_s;
         ch_ack_r    <= ch_ack_s;
         ch_rdata_r  <= ch_rdata_s;
         busy_r      <= busy_s;
      end
   end

   assign ch_ack    = ch_ack_r;
   assign ch_rdata  = ch_rdata_r;
   assign ram_addr  = ram_addr_r;
   assign ram_wdata = ram_wdata_r;
   assign ram_rd    = ram_rd_r;
   assign ram_wr    = ram_wr_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_mobo_bus_arb.sv
// Directed bench for mobo_bus_arb: one instance with WAIT_CYC=1, one with WAIT_CYC=0.
// Grant-order expectations follow MOBO_BUS_RR_EN when the bench is built with it.
module tb_mobo_bus_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  ch_req, ch_we, ch_ack;
   logic [63:0] ch_addr, ch_wdata;
   logic [31:0] ch_rdata, ram_addr, ram_wdata, ram_rdata;
   logic        ram_rd, ram_wr, busy;

   logic [1:0]  z_req, z_we, z_ack;
   logic [63:0] z_addr, z_wdata;
   logic [31:0] z_rdata, z_ram_addr, z_ram_wdata, z_ram_rdata;
   logic        z_rd, z_wr, z_busy;

   int errs = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mobo_bus_arb #(.DATA_W(32), .ADDR_W(32), .N_CH(2), .WAIT_CYC(1)) dut (
      .clk(clk), .rst(rst), .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr),
      .ch_wdata(ch_wdata), .ch_ack(ch_ack), .ch_rdata(ch_rdata), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_rd(ram_rd), .ram_wr(ram_wr),
      .busy(busy)
   );

   mobo_bus_arb #(.DATA_W(32), .ADDR_W(32), .N_CH(2), .WAIT_CYC(0)) dut0 (
      .clk(clk), .rst(rst), .ch_req(z_req), .ch_we(z_we), .ch_addr(z_addr),
      .ch_wdata(z_wdata), .ch_ack(z_ack), .ch_rdata(z_rdata), .ram_addr(z_ram_addr),
      .ram_wdata(z_ram_wdata), .ram_rdata(z_ram_rdata), .ram_rd(z_rd), .ram_wr(z_wr),
      .busy(z_busy)
   );

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Follows one transaction from the current cycle until its ack (bounded); cycle 1 is the first after the sampling edge
   task automatic watch(input logic [31:0] ea, input logic [31:0] ed, input bit poke,
                        output int rd_n, output int wr_n, output int ack_at,
                        output logic [1:0] ack_v, output int bad);
      rd_n = 0; wr_n = 0; ack_at = -1; ack_v = 2'b00; bad = 0;
      for (int c = 1; c <= 16 && ack_at < 0; c++) begin
         tick();
         if (ram_rd) rd_n++;
         if (ram_wr) wr_n++;
         if (ram_rd && ram_wr) bad++;
         if ((ram_rd || ram_wr) && ram_addr !== ea) bad++;
         if (ram_wr && ram_wdata !== ed) bad++;
         if (ch_ack !== 2'b00) begin
            ack_at = c;
            ack_v  = ch_ack;
         end
         if (poke && c == 1) begin
            ch_addr[31:0] = 32'h99;
            ch_req        = 2'b00;
         end
      end
   endtask

   int          rd_n, wr_n, ack_at, bad, n_ack, zrd, za1, za2, zn;
   logic [1:0]  ack_v;
   logic [1:0]  exp_ack [4];
   logic [31:0] exp_addr [4];

   initial begin
      rst = 1'b1;
      ch_req = 2'b00; ch_we = 2'b00; ch_addr = 64'd0; ch_wdata = 64'd0; ram_rdata = 32'd0;
      z_req = 2'b00; z_we = 2'b00; z_addr = 64'd0; z_wdata = 64'd0; z_ram_rdata = 32'h5A5A5A5A;
      repeat (2) tick();
      check_val("rst_rd",    64'(ram_rd),    64'd0);
      check_val("rst_wr",    64'(ram_wr),    64'd0);
      check_val("rst_busy",  64'(busy),      64'd0);
      check_val("rst_ack",   64'(ch_ack),    64'd0);
      check_val("rst_addr",  64'(ram_addr),  64'd0);
      check_val("rst_rdata", 64'(ch_rdata),  64'd0);
      rst = 1'b0;
      tick();

      // ch0 read of 0x10; address changed to 0x99 and req dropped after the latch
      ch_addr[31:0] = 32'h10; ch_we = 2'b00; ram_rdata = 32'hCAFEBABE; ch_req = 2'b01;
      watch(32'h10, 32'h0, 1'b1, rd_n, wr_n, ack_at, ack_v, bad);
      check_val("rd_strobe_n", 64'(rd_n),     64'd2);
      check_val("rd_wr_n",     64'(wr_n),     64'd0);
      check_val("rd_ack_at",   64'(ack_at),   64'd3);
      check_val("rd_ack_v",    64'(ack_v),    64'd1);
      check_val("rd_stable",   64'(bad),      64'd0);
      check_val("rd_data",     64'(ch_rdata), 64'hCAFEBABE);
      check_val("rd_addr",     64'(ram_addr), 64'h10);
      check_val("done_busy",   64'(busy),     64'd1);
      tick();
      check_val("idle_ack",    64'(ch_ack),   64'd0);
      check_val("idle_busy",   64'(busy),     64'd0);

      // ch1 write: read data register must keep the earlier value
      ch_addr[63:32] = 32'h20; ch_wdata[63:32] = 32'h12345678; ch_we = 2'b10;
      ram_rdata = 32'hDEADBEEF; ch_req = 2'b10;
      watch(32'h20, 32'h12345678, 1'b0, rd_n, wr_n, ack_at, ack_v, bad);
      check_val("wr_strobe_n", 64'(wr_n),      64'd2);
      check_val("wr_rd_n",     64'(rd_n),      64'd0);
      check_val("wr_ack_at",   64'(ack_at),    64'd3);
      check_val("wr_ack_v",    64'(ack_v),     64'd2);
      check_val("wr_stable",   64'(bad),       64'd0);
      check_val("wr_wdata",    64'(ram_wdata), 64'h12345678);
      check_val("wr_rdata",    64'(ch_rdata),  64'hCAFEBABE);
      ch_req = 2'b00; ch_addr[31:0] = 32'h10; ch_we = 2'b00;
      tick();

      // both channels held for four back-to-back transactions
`ifdef MOBO_BUS_RR_EN
      exp_ack[0] = 2'b01; exp_ack[1] = 2'b10; exp_ack[2] = 2'b01; exp_ack[3] = 2'b10;
      exp_addr[0] = 32'h10; exp_addr[1] = 32'h20; exp_addr[2] = 32'h10; exp_addr[3] = 32'h20;
`else
      exp_ack[0] = 2'b01; exp_ack[1] = 2'b01; exp_ack[2] = 2'b01; exp_ack[3] = 2'b01;
      exp_addr[0] = 32'h10; exp_addr[1] = 32'h10; exp_addr[2] = 32'h10; exp_addr[3] = 32'h10;
`endif
      ch_req = 2'b11;
      for (int t = 0; t < 4; t++) begin
         watch(exp_addr[t], 32'h0, 1'b0, rd_n, wr_n, ack_at, ack_v, bad);
         check_val($sformatf("arb_grant%0d", t), 64'(ack_v),  64'(exp_ack[t]));
         check_val($sformatf("arb_lat%0d", t),   64'(ack_at), (t == 0) ? 64'd3 : 64'd4);
         check_val($sformatf("arb_ok%0d", t),    64'(bad),    64'd0);
      end
      ch_req = 2'b00;
      tick();

      // reset in the second ACCESS cycle aborts without ack
      ch_req = 2'b01;
      tick();
      ch_req = 2'b00;
      tick();
      check_val("pre_rst_rd", 64'(ram_rd), 64'd1);
      rst = 1'b1;
      #1;
      check_val("rst_mid_rd",   64'(ram_rd), 64'd0);
      check_val("rst_mid_busy", 64'(busy),   64'd0);
      check_val("rst_mid_ack",  64'(ch_ack), 64'd0);
      tick();
      rst = 1'b0;
      n_ack = 0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (ch_ack !== 2'b00) n_ack++;
      end
      check_val("rst_no_ack", 64'(n_ack),    64'd0);
      check_val("rst_rdata0", 64'(ch_rdata), 64'd0);
      ch_addr[63:32] = 32'h20; ch_wdata[63:32] = 32'hA5A5F00D; ch_we = 2'b10; ch_req = 2'b10;
      watch(32'h20, 32'hA5A5F00D, 1'b0, rd_n, wr_n, ack_at, ack_v, bad);
      check_val("post_rst_ack_at", 64'(ack_at), 64'd3);
      check_val("post_rst_ack_v",  64'(ack_v),  64'd2);
      check_val("post_rst_wr_n",   64'(wr_n),   64'd2);
      ch_req = 2'b00; ch_we = 2'b00;
      tick();

      // zero-wait instance: two back-to-back reads, req dropped during the second
      z_addr[31:0] = 32'h30; z_we = 2'b00; z_req = 2'b01;
      zrd = 0; za1 = -1; za2 = -1; zn = 0;
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (z_rd) zrd++;
         if (z_ack !== 2'b00) begin
            zn++;
            if (za1 < 0) za1 = c;
            else za2 = c;
         end
         if (c == 4) z_req = 2'b00;
      end
      check_val("z_strobe_n", 64'(zrd), 64'd2);
      check_val("z_ack_at",   64'(za1), 64'd2);
      check_val("z_period",   64'(za2), 64'd5);
      check_val("z_ack_n",    64'(zn),  64'd2);
      check_val("z_rdata",    64'(z_rdata), 64'h5A5A5A5A);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
